// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub_i request line.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_in_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] res_o;
  logic             c_out_o;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_i;

  modport slave (
    input  valid_i, a_i, b_i, c_in_i, ready_i, sub_i,
    output ready_o, valid_o, res_o, c_out_o
  );
  modport master (
    output valid_i, a_i, b_i, c_in_i, ready_i, sub_i,
    input  ready_o, valid_o, res_o, c_out_o
  );
`else
  modport slave (
    input  valid_i, a_i, b_i, c_in_i, ready_i,
    output ready_o, valid_o, res_o, c_out_o
  );
  modport master (
    output valid_i, a_i, b_i, c_in_i, ready_i,
    input  ready_o, valid_o, res_o, c_out_o
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around a single full_adder, LSB first.
// Define SERIAL_ADDER_SUB_EN to enable subtraction via sub_i.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// state | meaning
// IDLE  | ready_o=1, waiting for operands; last result held
// RUN   | one operand bit per edge through full_adder
// DONE  | valid_o=1, result held until ready_i
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  serial_adder_if.slave     bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             sub_req;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_req = bus.sub_i;
`else
  assign sub_req = 1'b0;
`endif

  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          a_sh_d  = bus.a_i;
          // Subtraction is A + ~B + 1; c_in_i is ignored in that mode.
          b_sh_d  = sub_req ? ~bus.b_i : bus.b_i;
          carry_d = sub_req ? 1'b1 : bus.c_in_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.res_o   = res_q;
  assign bus.c_out_o = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, stall/reset sequences,
// randomised operations against an arithmetic reference.
module tb_serial_adder;
  localparam int W = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    check("ready_valid_exclusive", {31'b0, bus.ready_o & bus.valid_o}, 32'd0);
  endtask

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub_i = s;
`else
    if (s) $display("sub requested without SERIAL_ADDER_SUB_EN");
`endif
  endtask

  // One full operation; stall = cycles of ready_i=0 once valid_o is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int stall, input bit pulse,
                        output logic [W-1:0] res, output logic cout, output int lat);
    int n;
    logic [W-1:0] r0;
    logic c0;
    n = 0;
    while (!bus.ready_o && n < 50) begin tick(); n++; end
    check("wait_ready", {31'b0, bus.ready_o}, 32'd1);
    bus.valid_i = 1'b1; bus.a_i = a; bus.b_i = b; bus.c_in_i = cin; set_sub(sub);
    bus.ready_i = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < W + 5) begin
      check("busy_not_ready", {31'b0, bus.ready_o}, 32'd0);
      bus.a_i = W'($urandom); bus.b_i = W'($urandom); bus.c_in_i = 1'($urandom);
      set_sub(1'($urandom));
      bus.valid_i = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      lat++;
    end
    res = bus.res_o; cout = bus.c_out_o;
    r0 = res; c0 = cout;
    for (int i = 0; i < stall; i++) begin
      bus.valid_i = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      check("stall_valid", {31'b0, bus.valid_o}, 32'd1);
      check("stall_res", {24'b0, bus.res_o}, {24'b0, r0});
      check("stall_cout", {31'b0, bus.c_out_o}, {31'b0, c0});
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check("post_hs_valid", {31'b0, bus.valid_o}, 32'd0);
    check("post_hs_ready", {31'b0, bus.ready_o}, 32'd1);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] res, input logic cout,
                              input int lat, input logic [W:0] exp);
    check({name, "_res"}, {24'b0, res}, {24'b0, exp[W-1:0]});
    check({name, "_cout"}, {31'b0, cout}, {31'b0, exp[W]});
    check({name, "_latency"}, lat, W);
  endtask

  initial begin
    vec_t vecs[6];
    logic [W-1:0] res, ra, rb;
    logic cout, rc;
    int lat, stall;
    logic [W:0] model;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.a_i = '0; bus.b_i = '0; bus.c_in_i = 1'b0;
    set_sub(1'b0);

    #12;
    check("rst_ready", {31'b0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
    check("rst_res", {24'b0, bus.res_o}, 32'd0);
    check("rst_cout", {31'b0, bus.c_out_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0, 1'b0, res, cout, lat);
      check_result($sformatf("vec%0d", i), res, cout, lat, {vecs[i].exp_cout, vecs[i].exp_res});
    end

    // Backpressure with stray valid_i pulses; no second result may follow.
    run_op(8'h3C, 8'h05, 1'b0, 1'b0, 5, 1'b1, res, cout, lat);
    check_result("stall", res, cout, lat, 9'h041);
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check("no_second_result", {31'b0, bus.valid_o}, 32'd0);
      check("idle_holds_res", {24'b0, bus.res_o}, 32'h41);
    end

    // Reset during RUN bit 3.
    bus.valid_i = 1'b1; bus.a_i = 8'hA5; bus.b_i = 8'h5A; bus.c_in_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b1;
    #1;
    check("midrst_ready", {31'b0, bus.ready_o}, 32'd1);
    check("midrst_valid", {31'b0, bus.valid_o}, 32'd0);
    check("midrst_res", {24'b0, bus.res_o}, 32'd0);
    check("midrst_cout", {31'b0, bus.c_out_o}, 32'd0);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      tick();
      check("midrst_no_valid", {31'b0, bus.valid_o}, 32'd0);
    end
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b0, res, cout, lat);
    check_result("after_rst", res, cout, lat, 9'h030);

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      stall = $urandom_range(0, 3);
      model = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      run_op(ra, rb, rc, 1'b0, stall, 1'($urandom), res, cout, lat);
      check_result("rand", res, cout, lat, model);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b0, res, cout, lat);
    check_result("sub_borrow", res, cout, lat, 9'h0FE);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 0, 1'b0, res, cout, lat);
    check_result("sub_noborrow", res, cout, lat, 9'h102);
    for (int i = 0; i < 50; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      model = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
      run_op(ra, rb, 1'($urandom), 1'b1, $urandom_range(0, 2), 1'b0, res, cout, lat);
      check_result("rand_sub", res, cout, lat, model);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
